// File: rtl/gpu_lsu.sv
// gpu_lsu: per-thread load/store unit bridging decoded LDR/STR, the register file and the memory arbiter.
module gpu_lsu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic [1:0]            rd_addr,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_valid,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_ready,
    output logic                  rf_write_en,
    output logic [1:0]            rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [2:0] {IDLE, READ_REQ, WRITE_REQ, WRITEBACK, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic timeout;
    assign addr_in = ADDR_WIDTH'(rs_data);
    // Firing on the edge where the count would reach TIMEOUT keeps valid high for exactly TIMEOUT cycles.
    assign timeout = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            rf_write_en       <= 1'b0;
            rf_write_addr     <= '0;
            rf_write_data     <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            done        <= 1'b0;
            rf_write_en <= 1'b0;
            case (state)
                IDLE: if (start && enable) begin
                    mem_read_address  <= addr_in;
                    mem_write_address <= addr_in;
                    mem_write_data    <= rt_data;
                    rf_write_addr     <= rd_addr;
                    error             <= 1'b0;
                    cnt               <= '0;
                    busy              <= 1'b1;
                    if (is_load) begin
                        state          <= READ_REQ;
                        mem_read_valid <= 1'b1;
                    end else if (is_store) begin
                        state           <= WRITE_REQ;
                        mem_write_valid <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                READ_REQ: if (mem_read_ready) begin
                    rf_write_data  <= mem_read_data;
                    mem_read_valid <= 1'b0;
                    rf_write_en    <= rf_write_addr != 2'b10;
                    state          <= WRITEBACK;
                end else if (timeout) begin
                    mem_read_valid <= 1'b0;
                    error          <= 1'b1;
                    done           <= 1'b1;
                    state          <= DONE;
                end else begin
                    cnt <= (&cnt) ? cnt : cnt + 1'b1;
                end
                WRITE_REQ: if (mem_write_ready || timeout) begin
                    mem_write_valid <= 1'b0;
                    error           <= !mem_write_ready;
                    done            <= 1'b1;
                    state           <= DONE;
                end else begin
                    cnt <= (&cnt) ? cnt : cnt + 1'b1;
                end
                WRITEBACK: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_lsu.sv
// tb_gpu_lsu: vector table plus scoreboard of expected handshake, writeback and done events for gpu_lsu.
module tb_gpu_lsu;
    localparam int T = 4;
    logic clk = 1'b0;
    logic reset, enable, start, is_load, is_store;
    logic [7:0] rs_data, rt_data, mem_read_data, mem_read_address, mem_write_address, mem_write_data, rf_write_data;
    logic [1:0] rd_addr, rf_write_addr;
    logic mem_read_ready, mem_write_ready, mem_read_valid, mem_write_valid, rf_write_en, busy, done, error;

    always #5 clk = ~clk;

    gpu_lsu #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .is_load(is_load), .is_store(is_store),
        .rs_data(rs_data), .rt_data(rt_data), .rd_addr(rd_addr),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready), .rf_write_en(rf_write_en),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .busy(busy), .done(done), .error(error)
    );

    typedef struct {
        logic ld, st;
        logic [7:0] rs, rt;
        logic [1:0] rd;
        logic [7:0] md;
        int dly;
        int done_cyc;
        logic err;
    } vec_t;
    typedef struct {
        int kind;
        int cyc;
        logic [7:0] a, d;
    } ev_t;

    ev_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int cyc, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.cyc = cyc; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int cyc, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_unexpected: got event %0d in cycle %0d, want none", kind, cyc);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", kind, e.kind);
            chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
            chk($sformatf("ev%0d_addr", e.kind), {24'b0, a}, {24'b0, e.a});
            chk($sformatf("ev%0d_data", e.kind), {24'b0, d}, {24'b0, e.d});
        end
    endtask

    task automatic run(input vec_t v);
        bit to, seen;
        int exp_v, nv;
        logic rdy;
        to = (v.ld || v.st) && v.dly >= T;
        exp_v = !(v.ld || v.st) ? 0 : to ? T : v.dly + 1;
        if (v.ld) begin
            if (to) push(3, T + 1, 8'h0, 8'h1);
            else begin
                push(0, v.dly + 1, v.rs, 8'h0);
                if (v.rd != 2'b10) push(2, v.dly + 2, {6'b0, v.rd}, v.md);
                push(3, v.dly + 3, 8'h0, 8'h0);
            end
        end else if (v.st) begin
            if (to) push(3, T + 1, 8'h0, 8'h1);
            else begin
                push(1, v.dly + 1, v.rs, v.rt);
                push(3, v.dly + 2, 8'h0, 8'h0);
            end
        end else push(3, 1, 8'h0, 8'h0);
        enable = 1'b1; start = 1'b1; is_load = v.ld; is_store = v.st;
        rs_data = v.rs; rt_data = v.rt; rd_addr = v.rd;
        seen = 0; nv = 0;
        for (int k = 1; k <= v.done_cyc + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; enable = 1'($urandom); is_load = 1'($urandom); is_store = 1'($urandom);
                rs_data = 8'($urandom); rt_data = 8'($urandom); rd_addr = 2'($urandom);
            end
            rdy = (k > v.dly);
            mem_read_ready = rdy; mem_write_ready = rdy;
            mem_read_data = rdy ? v.md : 8'hEE;
            chk("busy", busy, k <= v.done_cyc);
            chk("error", error, v.err && k == v.done_cyc);
            if (mem_read_valid) begin
                nv++;
                chk("rd_addr_hold", mem_read_address, v.rs);
                if (rdy) observe(0, k, mem_read_address, 8'h0);
            end
            if (mem_write_valid) begin
                nv++;
                chk("wr_addr_hold", mem_write_address, v.rs);
                chk("wr_data_hold", mem_write_data, v.rt);
                if (rdy) observe(1, k, mem_write_address, mem_write_data);
            end
            if (rf_write_en) observe(2, k, {6'b0, rf_write_addr}, rf_write_data);
            if (done) begin
                chk("done_excl", {mem_read_valid, mem_write_valid, rf_write_en}, 0);
                observe(3, k, 8'h0, {7'b0, error});
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        chk("valid_cycles", nv, exp_v);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("err_sticky", error, v.err);
    endtask

    vec_t vt[10];

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 8'h23, 8'h00, 2'd1, 8'h5A, 0, 3, 1'b0};
        vt[1] = '{1'b1, 1'b0, 8'h47, 8'h00, 2'd3, 8'h9E, 3, 6, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'h10, 8'hC3, 2'd0, 8'h00, 1, 3, 1'b0};
        vt[3] = '{1'b1, 1'b0, 8'h31, 8'h00, 2'd2, 8'h77, 0, 3, 1'b0};
        vt[4] = '{1'b0, 1'b0, 8'h55, 8'h66, 2'd1, 8'h00, 0, 1, 1'b0};
        vt[5] = '{1'b1, 1'b0, 8'h66, 8'h00, 2'd0, 8'h12, 255, 5, 1'b1};
        vt[6] = '{1'b0, 1'b1, 8'h80, 8'h11, 2'd0, 8'h00, 0, 2, 1'b0};
        vt[7] = '{1'b1, 1'b1, 8'h0F, 8'h5E, 2'd1, 8'hAB, 2, 5, 1'b0};
        vt[8] = '{1'b0, 1'b1, 8'hF0, 8'h3C, 2'd3, 8'h00, 255, 5, 1'b1};
        vt[9] = '{1'b1, 1'b0, 8'hFF, 8'h00, 2'd0, 8'h00, 1, 4, 1'b0};
        reset = 1'b1; enable = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        rs_data = 8'h0; rt_data = 8'h0; rd_addr = 2'd0;
        mem_read_ready = 1'b0; mem_read_data = 8'h0; mem_write_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {mem_read_valid, mem_write_valid, rf_write_en, busy, done, error}, 0);
        chk("rst_addr", {mem_read_address, mem_write_address}, 0);
        chk("rst_data", {mem_write_data, rf_write_data, 6'b0, rf_write_addr}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) run(vt[i]);

        enable = 1'b0; start = 1'b1; is_load = 1'b1; is_store = 1'b0; rs_data = 8'h44;
        @(negedge clk);
        start = 1'b0; enable = 1'b1;
        chk("disabled_start", {busy, mem_read_valid}, 0);

        start = 1'b1; is_load = 1'b0; is_store = 1'b1; rs_data = 8'h5C; rt_data = 8'h21;
        @(negedge clk);
        start = 1'b0;
        chk("stall_wv_c1", mem_write_valid, 1);
        @(negedge clk);
        chk("stall_wv_c2", mem_write_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ctrl", {mem_write_valid, busy, done}, 0);
        chk("rst_mid_addr", {mem_write_address, mem_write_data}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", {done, mem_write_valid, busy}, 0);
        end

        start = 1'b1; is_load = 1'b1; is_store = 1'b0; rs_data = 8'h3A; rd_addr = 2'd3;
        @(negedge clk);
        chk("busy_ld_c1", mem_read_valid, 1);
        start = 1'b1; is_load = 1'b0; is_store = 1'b1; rs_data = 8'h99; rt_data = 8'h77; rd_addr = 2'd0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ign_addr", {mem_read_valid, mem_write_valid, mem_read_address}, {16'b0, 1'b1, 1'b0, 8'h00, 8'h3A} >> 0 & 32'h2FF | 32'h200);
        mem_read_ready = 1'b1; mem_read_data = 8'h44;
        @(negedge clk);
        mem_read_ready = 1'b0;
        chk("busy_ign_wb", {rf_write_en, rf_write_addr, rf_write_data}, {1'b1, 2'd3, 8'h44});
        @(negedge clk);
        chk("busy_ign_done", {done, mem_write_valid}, 2'b10);
        @(negedge clk);
        chk("busy_ign_idle", {busy, mem_write_valid, done}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
